// File: rtl/decoder_select_sequencer.sv
// ----------------------------------------------------------------------------
// decoder_select_sequencer
//
// Scans a 2-bit decoder select (a = idx[1], b = idx[0]) across the lines
// enabled in mask. Each selected index is held for dwell+1 cycles, then the
// select advances to the next enabled line in ascending order, wrapping from
// line 3 back to line 0.
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   scan enable (level); low forces IDLE, beats hold and advance
//   hold   in   freezes index and dwell counter while scanning
//   dwell  in   [7:0] cycles per index minus one, sampled at load/reload
//   mask   in   [3:0] per-line enable, sampled at load/advance
//   a      out  select MSB (registered)
//   b      out  select LSB (registered)
//   valid  out  a/b carry a live selection (registered)
//   wrap   out  one-cycle pulse when the new index is <= the old one
// ----------------------------------------------------------------------------
module decoder_select_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       hold,
   input  logic [7:0] dwell,
   input  logic [3:0] mask,
   output logic       a,
   output logic       b,
   output logic       valid,
   output logic       wrap
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q,   idx_d;
   logic [7:0] cnt_q,   cnt_d;
   logic       valid_q, valid_d;
   logic       wrap_q,  wrap_d;

   // Lowest enabled line; only meaningful when m != 0.
   function automatic logic [1:0] lowest_set(input logic [3:0] m);
      logic [1:0] r;
      if (m[0])      r = 2'd0;
      else if (m[1]) r = 2'd1;
      else if (m[2]) r = 2'd2;
      else           r = 2'd3;
      return r;
   endfunction

   // First enabled line searching cur+1, cur+2, cur+3, cur (mod 4).
   // Returns cur itself when it is the only enabled line.
   function automatic logic [1:0] next_set(input logic [1:0] cur,
                                           input logic [3:0] m);
      logic [1:0] r;
      logic [1:0] cand;
      logic       found;
      r     = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = cur + 2'(i);
         if (!found && m[cand]) begin
            r     = cand;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;

      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mask != '0) begin
                  state_d = SCAN;
                  idx_d   = lowest_set(mask);
                  cnt_d   = dwell;
                  valid_d = 1'b1;
               end
            end
            SCAN: begin
               if (hold) begin
                  // everything frozen; wrap already defaulted low
               end else if (cnt_q != '0) begin
                  cnt_d = cnt_q - 8'd1;
               end else if (mask == '0) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  cnt_d   = '0;
                  valid_d = 1'b0;
               end else begin
                  idx_d  = next_set(idx_q, mask);
                  cnt_d  = dwell;
                  wrap_d = (next_set(idx_q, mask) <= idx_q);
               end
            end
            default: begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   // idx_q is held at 0 whenever IDLE, so a/b can come straight from it.
   assign a     = idx_q[1];
   assign b     = idx_q[0];
   assign valid = valid_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// ----------------------------------------------------------------------------
// tb_decoder_select_sequencer
//
// Directed stimulus for decoder_select_sequencer. Each phase pushes the
// hand-derived {a,b,wrap} sequence it expects into a queue; a monitor pops
// one entry on every cycle the DUT shows valid=1 and compares.
// ----------------------------------------------------------------------------
module tb_decoder_select_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       hold;
   logic [7:0] dwell;
   logic [3:0] mask;
   logic       a;
   logic       b;
   logic       valid;
   logic       wrap;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0] exp_q[$];   // {a, b, wrap}
   string      phase = "reset";

   decoder_select_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .hold  (hold),
      .dwell (dwell),
      .mask  (mask),
      .a     (a),
      .b     (b),
      .valid (valid),
      .wrap  (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h expected %0h", phase, name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] ab, input logic w);
      exp_q.push_back({ab, w});
   endtask

   task automatic push_n(input logic [1:0] ab, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({ab, 1'b0});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_idle();
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_a",     32'(a),     32'd0);
      chk("idle_b",     32'(b),     32'd0);
      chk("idle_wrap",  32'(wrap),  32'd0);
      chk("queue_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard monitor: sample mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      logic [2:0] e;
      if (valid === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s/unexpected_valid: got {a,b,wrap}=%b%b%b expected no valid",
                     phase, a, b, wrap);
         end else begin
            e = exp_q.pop_front();
            if ({a, b, wrap} !== e) begin
               n_fail++;
               $display("FAIL %s/sel: got {a,b,wrap}=%b%b%b expected %b",
                        phase, a, b, wrap, e);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      hold  = 1'b0;
      dwell = 8'd0;
      mask  = 4'd0;

      // Reset state
      cyc(1);
      check_idle();
      rst_n = 1'b1;
      cyc(2);
      check_idle();

      // Basic scan: all lines, dwell=2, wrap on the 13th valid cycle
      phase = "basic";
      mask  = 4'b1111;
      dwell = 8'd2;
      push_n(2'b00, 3);
      push_n(2'b01, 3);
      push_n(2'b10, 3);
      push_n(2'b11, 3);
      push(2'b00, 1'b1);
      en = 1'b1;
      cyc(13);
      en = 1'b0;
      cyc(1);
      check_idle();

      // Priority: en drops in a cycle that would advance (dwell=0)
      phase = "priority";
      dwell = 8'd0;
      push(2'b00, 1'b0);
      push(2'b01, 1'b0);
      en = 1'b1;
      cyc(2);
      en = 1'b0;
      cyc(1);
      check_idle();

      // Sparse mask 1010, dwell=0: 01,11,01(w),11,01(w)
      phase = "sparse";
      mask  = 4'b1010;
      push(2'b01, 1'b0);
      push(2'b11, 1'b0);
      push(2'b01, 1'b1);
      push(2'b11, 1'b0);
      push(2'b01, 1'b1);
      en = 1'b1;
      cyc(5);
      en = 1'b0;
      cyc(1);
      check_idle();

      // Single line 0100, dwell=1; mask cleared mid-dwell only bites at advance
      phase = "single";
      mask  = 4'b0100;
      dwell = 8'd1;
      push(2'b10, 1'b0);
      push(2'b10, 1'b0);
      push(2'b10, 1'b1);
      push(2'b10, 1'b0);
      push(2'b10, 1'b1);
      push(2'b10, 1'b0);
      en = 1'b1;
      cyc(5);
      mask = 4'b0000;
      cyc(2);
      check_idle();
      en = 1'b0;
      cyc(1);

      // Hold: dwell=3, hold 5 cycles while on idx 1 -> idx 1 for 9 cycles
      phase = "hold";
      mask  = 4'b1111;
      dwell = 8'd3;
      push_n(2'b00, 4);
      push_n(2'b01, 9);
      push_n(2'b10, 4);
      push_n(2'b11, 4);
      push(2'b00, 1'b1);
      en = 1'b1;
      cyc(6);
      hold = 1'b1;
      cyc(5);
      hold = 1'b0;
      cyc(11);
      en = 1'b0;
      cyc(1);
      check_idle();

      // Async reset mid-scan, then restart from lowest bit of a new mask
      phase = "async_rst";
      dwell = 8'd1;
      push(2'b00, 1'b0);
      push(2'b00, 1'b0);
      push(2'b01, 1'b0);
      en = 1'b1;
      cyc(4);
      chk("pre_rst_b", 32'(b), 32'd1);
      rst_n = 1'b0;
      #2;
      check_idle();
      mask = 4'b0110;
      push(2'b01, 1'b0);
      push(2'b01, 1'b0);
      push(2'b10, 1'b0);
      push(2'b10, 1'b0);
      push(2'b01, 1'b1);
      #1;
      rst_n = 1'b1;
      cyc(5);
      en = 1'b0;
      cyc(1);
      check_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decoder_select_sequencer.md
DECODER_SELECT_SEQUENCER -- requirements
Module: decoder_select_sequencer

Interface
REQ-001 SHALL have one clock, clk, and reset rst_n; reset is asynchronous and active-low.
REQ-002 SHALL have no parameters.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  scan enable; level-sensitive.
REQ-006 hold  input  1  freezes the dwell counter and the current index while high.
REQ-007 dwell  input  8  dwell count; each index is held for dwell+1 cycles.
REQ-008 mask  input  4  per-line enable; bit k set means index k takes part in the scan.
REQ-009 a  output  1  decoder select MSB, equal to idx[1]; registered.
REQ-010 b  output  1  decoder select LSB, equal to idx[0]; registered.
REQ-011 valid  output  1  high when a/b carry a live selection; registered.
REQ-012 wrap  output  1  one-cycle pulse when the scan wraps to the lowest enabled index; registered.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-014 In IDLE, a=0, b=0, valid=0, wrap=0, and the counter is 0.
REQ-015 IDLE->SCAN when en=1 and mask!=0: idx loads the lowest set mask bit, counter loads dwell, and valid=1 from the next cycle.
REQ-016 IDLE with en=1 and mask=0 SHALL remain in IDLE.
REQ-017 In SCAN with hold=0 and counter!=0, the counter SHALL decrement by 1 and idx is unchanged.
REQ-018 In SCAN with hold=0 and counter==0, the block SHALL advance:
- idx becomes the next set mask bit, searching idx+1, idx+2, idx+3, idx (mod 4);
- mask is sampled in that cycle;
- the counter reloads from dwell sampled in that cycle.
REQ-019 wrap SHALL be 1 for exactly the cycle in which the new idx first appears, when new idx <= old idx numerically, including the single-bit mask case; otherwise wrap=0.
REQ-020 With hold=1 in SCAN, idx, the counter and valid SHALL be frozen, and wrap=0.
REQ-021 An advance with mask=0 SHALL go to IDLE, with outputs as in REQ-014 from the next cycle.
REQ-022 en=0 in any state SHALL force IDLE on the next edge; en has priority over hold and over an advance.
REQ-023 dwell=0 SHALL advance every cycle, one cycle per index.
REQ-024 Mask changes between advances SHALL NOT affect the current idx; they take effect only at the next advance.
REQ-025 Throughput/latency:
- first valid selection 1 cycle after en rises;
- every enabled index is visited once per (popcount(mask) x (dwell+1)) cycles, with no hold.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 SHALL immediately force:
- state=IDLE, idx=0, counter=0;
- a=0, b=0, valid=0, wrap=0.
REQ-028 Reset assertion mid-scan SHALL abort the scan.
REQ-029 After rst_n deasserts, the first transition SHALL occur no earlier than the first rising clk edge.

Verification
REQ-030 Basic scan: mask=4'b1111, dwell=2, en rises -> {a,b} sequence 00,00,00,01,01,01,10,10,10,11,11,11,00; valid=1 throughout; wrap=1 on the 13th valid cycle.
REQ-031 Sparse mask: mask=4'b1010, dwell=0 -> {a,b} alternates 01,11,01,11; wrap=1 on each 01 after the first.
REQ-032 Single line and empty mask:
- mask=4'b0100, dwell=1 -> {a,b}=10 constant, wrap=1 every 2nd cycle;
- then mask changes to 0 -> IDLE and valid=0 at the cycle after the next advance.
REQ-033 Hold: mask=4'b1111, dwell=3, hold=1 for 5 cycles mid-dwell on idx 1 -> idx 1 held for 4+5 cycles total, with no wrap.
REQ-034 Priority: en=0 in the same cycle as an advance -> IDLE next cycle with valid=0, and the advance is not taken.
REQ-035 Async reset: rst_n pulsed low between clock edges mid-scan -> a, b, valid and wrap go to 0 before the next edge; re-enable restarts from the lowest set mask bit.
